// File: rtl/sram_arbiter.sv
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Two-port SRAM arbiter (cache s0, DMA/video s1) with bounded s0 burst.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_arbiter #(
    parameter int MAX_S0_CONSEC = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [16:0] s0_addr,
    input  logic [31:0] s0_wrdata,
    input  logic [3:0]  s0_bytesel,
    input  logic        s0_wren,
    input  logic        s0_strobe,
    output logic        s0_wait,
    output logic [31:0] s0_rddata,
    input  logic [16:0] s1_addr,
    input  logic [31:0] s1_wrdata,
    input  logic [3:0]  s1_bytesel,
    input  logic        s1_wren,
    input  logic        s1_strobe,
    output logic        s1_wait,
    output logic [31:0] s1_rddata,
    output logic [16:0] m_addr,
    output logic [31:0] m_wrdata,
    output logic [3:0]  m_bytesel,
    output logic        m_wren,
    output logic        m_strobe,
    input  logic        m_wait,
    input  logic [31:0] m_rddata
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_S0_CONSEC);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic       g;
    logic [3:0] consec;
    logic       pick;
    logic       g_strobe;
    logic       in_grant;

    // With both requesting, s1 wins only once s0 has used its burst allowance.
    always_comb begin
        pick = s1_strobe;
        if (s0_strobe && s1_strobe) begin
            pick = (consec == MAX_CNT);
        end
    end

    assign g_strobe = g ? s1_strobe : s0_strobe;
    assign in_grant = (state == GRANT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            g      <= 1'b0;
            consec <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (s0_strobe || s1_strobe) begin
                        state <= GRANT;
                        g     <= pick;
                        if (!pick && s1_strobe) begin
                            consec <= (consec == MAX_CNT) ? consec : consec + 4'd1;
                        end else begin
                            consec <= 4'd0;
                        end
                    end
                end
                GRANT: begin
                    // Leave on completion or when the granted requester abandons.
                    if (!g_strobe || !m_wait) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_addr    = g ? s1_addr    : s0_addr;
    assign m_wrdata  = g ? s1_wrdata  : s0_wrdata;
    assign m_bytesel = g ? s1_bytesel : s0_bytesel;
    assign m_wren    = g ? s1_wren    : s0_wren;
    assign m_strobe  = in_grant && g_strobe;

    assign s0_wait = s0_strobe && !(in_grant && !g && !m_wait);
    assign s1_wait = s1_strobe && !(in_grant &&  g && !m_wait);

    assign s0_rddata = m_rddata;
    assign s1_rddata = m_rddata;

endmodule

`default_nettype wire
